// File: rtl/wash_controller.sv
// Washing-machine programme sequencer (WASH -> RINSE -> SPIN) with pause/resume,
// driving the two-digit remaining/total time display and the water-level indicator.
module wash_controller #(
    parameter int TICK_DIV  = 50000000,
    parameter int WASH_T    = 9,
    parameter int RINSE_T   = 6,
    parameter int SPIN_T    = 3,
    parameter int WATER_LVL = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_btn,
    input  logic       start_btn,
    input  logic       mode_btn,
    output logic       power_light,
    output logic [6:0] current_time,
    output logic [6:0] total_time,
    output logic [2:0] current_water,
    output logic [2:0] phase,
    output logic       done
);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_IDLE  = 3'd1,
        S_WASH  = 3'd2,
        S_RINSE = 3'd3,
        S_SPIN  = 3'd4,
        S_PAUSE = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam int              DIV_W     = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [6:0]      LEN_WASH  = 7'(WASH_T);
    localparam logic [6:0]      LEN_RINSE = 7'(RINSE_T);
    localparam logic [6:0]      LEN_SPIN  = 7'(SPIN_T);
    localparam logic [6:0]      SUM_P0    = 7'(WASH_T + RINSE_T + SPIN_T);
    localparam logic [6:0]      SUM_P1    = 7'(RINSE_T + SPIN_T);
    localparam logic [2:0]      WATER     = 3'(WATER_LVL);

    state_t           r_state, r_saved;
    logic [1:0]       r_prog;
    logic [DIV_W-1:0] r_div;
    logic [6:0]       r_left, r_cur, r_total;
    logic             r_power_q, r_start_q, r_mode_q;

    state_t           w_state_nxt, w_saved_nxt;
    logic [1:0]       w_prog_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic [6:0]       w_left_nxt, w_cur_nxt, w_total_nxt;
    logic             w_power_edge, w_start_edge, w_mode_edge, w_tick;

    function automatic logic [6:0] prog_sum(input logic [1:0] prog);
        case (prog)
            2'd0:    return SUM_P0;
            2'd1:    return SUM_P1;
            default: return LEN_SPIN;
        endcase
    endfunction

    assign w_power_edge = power_btn & ~r_power_q;
    assign w_start_edge = start_btn & ~r_start_q;
    assign w_mode_edge  = mode_btn  & ~r_mode_q;
    assign w_tick       = (r_state == S_WASH || r_state == S_RINSE || r_state == S_SPIN)
                          && (r_div == DIV_LAST);

    always_comb begin
        // NOTE: every next-value gets a hold default first, so no path leaves one unassigned (no latch).
        w_state_nxt = r_state;
        w_saved_nxt = r_saved;
        w_prog_nxt  = r_prog;
        w_div_nxt   = r_div;
        w_left_nxt  = r_left;
        w_cur_nxt   = r_cur;
        w_total_nxt = r_total;

        if (r_state != S_OFF && w_power_edge) begin
            w_state_nxt = S_OFF;
            w_prog_nxt  = 2'd0;
            w_div_nxt   = '0;
            w_left_nxt  = '0;
            w_cur_nxt   = '0;
            w_total_nxt = '0;
        end else begin
            case (r_state)
                S_OFF: if (w_power_edge) begin
                    w_state_nxt = S_IDLE;
                    w_prog_nxt  = 2'd0;
                    w_cur_nxt   = SUM_P0;
                    w_total_nxt = SUM_P0;
                end
                S_IDLE: if (w_start_edge) begin
                    w_div_nxt = '0;
                    case (r_prog)
                        2'd0:    begin w_state_nxt = S_WASH;  w_left_nxt = LEN_WASH;  end
                        2'd1:    begin w_state_nxt = S_RINSE; w_left_nxt = LEN_RINSE; end
                        default: begin w_state_nxt = S_SPIN;  w_left_nxt = LEN_SPIN;  end
                    endcase
                end else if (w_mode_edge) begin
                    w_prog_nxt  = (r_prog == 2'd2) ? 2'd0 : r_prog + 2'd1;
                    w_cur_nxt   = prog_sum(w_prog_nxt);
                    w_total_nxt = prog_sum(w_prog_nxt);
                end
                S_WASH, S_RINSE, S_SPIN: if (w_start_edge) begin
                    // Pausing on a terminal count leaves the divider there, so the tick lands right after resume.
                    w_saved_nxt = r_state;
                    w_state_nxt = S_PAUSE;
                end else begin
                    w_div_nxt = w_tick ? '0 : r_div + 1'b1;
                    if (w_tick) begin
                        w_cur_nxt  = r_cur - 7'd1;
                        w_left_nxt = r_left - 7'd1;
                        if (r_left == 7'd1) begin
                            case (r_state)
                                S_WASH:  begin w_state_nxt = S_RINSE; w_left_nxt = LEN_RINSE; end
                                S_RINSE: begin w_state_nxt = S_SPIN;  w_left_nxt = LEN_SPIN;  end
                                default: w_state_nxt = S_DONE;
                            endcase
                        end
                    end
                end
                S_PAUSE: if (w_start_edge) w_state_nxt = r_saved;
                S_DONE: if (w_start_edge) begin
                    w_state_nxt = S_IDLE;
                    w_cur_nxt   = prog_sum(r_prog);
                    w_total_nxt = prog_sum(r_prog);
                end
                default: w_state_nxt = S_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values together.
        if (rst) begin
            r_state   <= S_OFF;
            r_saved   <= S_OFF;
            r_prog    <= 2'd0;
            r_div     <= '0;
            r_left    <= '0;
            r_cur     <= '0;
            r_total   <= '0;
            r_power_q <= 1'b0;
            r_start_q <= 1'b0;
            r_mode_q  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_saved   <= w_saved_nxt;
            r_prog    <= w_prog_nxt;
            r_div     <= w_div_nxt;
            r_left    <= w_left_nxt;
            r_cur     <= w_cur_nxt;
            r_total   <= w_total_nxt;
            r_power_q <= power_btn;
            r_start_q <= start_btn;
            r_mode_q  <= mode_btn;
        end
    end

    assign power_light   = (r_state != S_OFF);
    assign current_time  = r_cur;
    assign total_time    = r_total;
    assign current_water = (r_state == S_WASH || r_state == S_RINSE) ? WATER : 3'd0;
    assign phase         = r_state;
    assign done          = (r_state == S_DONE);

endmodule

// File: tb/tb_wash_controller.sv
// Scoreboard bench for wash_controller: each driven cycle pushes the expected outputs,
// which are popped and compared one clock later, away from the active edge.
module tb_wash_controller;

    logic       clk = 1'b0;
    logic       rst, power_btn, start_btn, mode_btn;
    logic       power_light, done;
    logic [6:0] current_time, total_time;
    logic [2:0] current_water, phase;

    typedef struct packed {
        logic [2:0] ph;
        logic [6:0] cur;
        logic [6:0] tot;
        logic [2:0] wat;
        logic       pl;
        logic       dn;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    wash_controller #(
        .TICK_DIV(4), .WASH_T(2), .RINSE_T(2), .SPIN_T(1), .WATER_LVL(3)
    ) dut (
        .clk(clk), .rst(rst),
        .power_btn(power_btn), .start_btn(start_btn), .mode_btn(mode_btn),
        .power_light(power_light), .current_time(current_time), .total_time(total_time),
        .current_water(current_water), .phase(phase), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic compare_out();
        exp_t  e;
        string t;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            check({t, ".phase"}, phase, e.ph);
            check({t, ".cur"},   current_time, e.cur);
            check({t, ".tot"},   total_time, e.tot);
            check({t, ".water"}, current_water, e.wat);
            check({t, ".light"}, power_light, e.pl);
            check({t, ".done"},  done, e.dn);
        end
    endtask

    // One clock: drive inputs on the falling edge, expect the outputs after the next rising edge.
    task automatic drive(input logic r, input logic p, input logic s, input logic m,
                         input string tag, input int ph, input int cur, input int tot, input int wat);
        exp_t e;
        @(negedge clk);
        rst = r; power_btn = p; start_btn = s; mode_btn = m;
        e.ph  = 3'(ph);
        e.cur = 7'(cur);
        e.tot = 7'(tot);
        e.wat = 3'(wat);
        e.pl  = (ph != 0);
        e.dn  = (ph == 6);
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        int ticks, ph, wat;
        rst = 1'b1; power_btn = 1'b0; start_btn = 1'b0; mode_btn = 1'b0;

        drive(1, 0, 0, 0, "reset0", 0, 0, 0, 0);
        drive(1, 0, 0, 0, "reset1", 0, 0, 0, 0);
        drive(0, 0, 0, 0, "off",    0, 0, 0, 0);

        drive(0, 1, 0, 0, "power_on", 1, 5, 5, 0);
        drive(0, 0, 0, 0, "idle",     1, 5, 5, 0);

        drive(0, 0, 0, 1, "mode_p1", 1, 3, 3, 0);
        drive(0, 0, 0, 0, "idle_p1", 1, 3, 3, 0);
        drive(0, 0, 0, 1, "mode_p2", 1, 1, 1, 0);
        drive(0, 0, 0, 0, "idle_p2", 1, 1, 1, 0);
        drive(0, 0, 0, 1, "mode_p0", 1, 5, 5, 0);
        drive(0, 0, 0, 0, "idle_p0", 1, 5, 5, 0);

        // Start and mode together: start wins, programme 0 runs to completion.
        drive(0, 0, 1, 1, "start_mode", 2, 5, 5, 3);
        for (int k = 1; k <= 23; k++) begin
            ticks = k / 4;
            ph    = (ticks < 2) ? 2 : (ticks < 4) ? 3 : (ticks < 5) ? 4 : 6;
            wat   = (ph == 2 || ph == 3) ? 3 : 0;
            drive(0, 0, 0, 0, $sformatf("run_k%0d", k), ph, 5 - ticks, 5, wat);
        end

        drive(0, 0, 1, 0, "done_start", 1, 5, 5, 0);
        drive(0, 0, 0, 0, "idle_again", 1, 5, 5, 0);

        // Pause on the terminal-count cycle of WASH.
        drive(0, 0, 1, 0, "start2", 2, 5, 5, 3);
        for (int k = 1; k <= 3; k++) drive(0, 0, 0, 0, $sformatf("wash_k%0d", k), 2, 5, 5, 3);
        drive(0, 0, 1, 0, "pause_tc", 5, 5, 5, 0);
        for (int k = 1; k <= 10; k++) drive(0, 0, 0, 0, $sformatf("pause_hold%0d", k), 5, 5, 5, 0);
        drive(0, 0, 1, 0, "resume",      2, 5, 5, 3);
        drive(0, 0, 0, 0, "resume_tick", 2, 4, 5, 3);
        for (int k = 1; k <= 3; k++) drive(0, 0, 0, 0, $sformatf("wash_r%0d", k), 2, 4, 5, 3);
        drive(0, 0, 0, 0, "rinse",       3, 3, 5, 3);
        drive(0, 1, 0, 0, "power_rinse", 0, 0, 0, 0);
        drive(0, 0, 0, 0, "off2",        0, 0, 0, 0);

        // Mode ignored while running, then rst while paused.
        drive(0, 1, 0, 0, "power_on2",  1, 5, 5, 0);
        drive(0, 0, 0, 0, "idle3",      1, 5, 5, 0);
        drive(0, 0, 1, 0, "start3",     2, 5, 5, 3);
        drive(0, 0, 0, 0, "wash3_k1",   2, 5, 5, 3);
        drive(0, 0, 0, 1, "mode_in_run", 2, 5, 5, 3);
        drive(0, 0, 0, 0, "wash3_k3",   2, 5, 5, 3);
        drive(0, 0, 0, 0, "wash3_tick", 2, 4, 5, 3);
        drive(0, 0, 1, 0, "pause3",     5, 4, 5, 0);
        drive(0, 0, 0, 0, "pause3_hold", 5, 4, 5, 0);
        drive(1, 0, 0, 0, "rst_pause",  0, 0, 0, 0);
        drive(0, 0, 0, 0, "off3",       0, 0, 0, 0);

        // All three edges at once from IDLE: power has priority.
        drive(0, 1, 0, 0, "power_on3", 1, 5, 5, 0);
        drive(0, 0, 0, 0, "idle4",     1, 5, 5, 0);
        drive(0, 1, 1, 1, "all_edges", 0, 0, 0, 0);
        drive(0, 0, 0, 0, "off4",      0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
